// File: rtl/keypad_pkg.sv
// keypad_pkg: shared column/row types, frame class codes and the key position decoder
package keypad_pkg;

    typedef enum logic [1:0] {COL_A, COL_B, COL_C} col_t;
    typedef enum logic [1:0] {ROW_D, ROW_E, ROW_F, ROW_G} row_t;

    localparam logic [3:0] KEY_NONE = 4'hE;
    localparam logic [3:0] KEY_BAD  = 4'hF;

    // Returns {is_digit, number}; '*' and '#' on row g are not digits
    function automatic logic [4:0] key_decode(col_t c, row_t r);
        logic [3:0] base;
        base = (r == ROW_D) ? 4'd1 : (r == ROW_E) ? 4'd4 : 4'd7;
        return (r == ROW_G) ? {c == COL_B, 4'd0} : {1'b1, base + {2'b00, c}};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts consecutive equal frame classes, flags stable digit presses and tracks the held key
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_done,
    input  logic [3:0] cls,
    output logic       press,
    output logic [3:0] number,
    output logic       held
);

    logic [3:0] last;
    logic [3:0] cnt;
    logic [3:0] ncnt;
    logic       released;

    always_comb begin
        ncnt = (cls == KEY_BAD) ? 4'd0 : (cls != last) ? 4'd1 : (cnt == 4'(DEBOUNCE)) ? cnt : cnt + 4'd1;
        press = frame_done && ncnt == 4'(DEBOUNCE) && cls <= 4'd9;
        released = frame_done && ncnt == 4'(DEBOUNCE) && cls == KEY_NONE;
    end

    assign number = cls;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= KEY_NONE;
            cnt  <= 4'd0;
            held <= 1'b0;
        end else if (frame_done) begin
            last <= cls;
            cnt  <= ncnt;
            held <= press ? 1'b1 : released ? 1'b0 : held;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes the 3x4 keypad columns, classifies each scan frame and emits debounced key events
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       col_a,
    output logic       col_b,
    output logic       col_c,
    input  logic       row_d,
    input  logic       row_e,
    input  logic       row_f,
    input  logic       row_g,
    output logic       key_valid,
    output logic [3:0] key_number,
    input  logic       key_ready,
    output logic       overrun
);

    logic            run;
    col_t            col;
    logic [7:0]      dwell;
    logic [3:0]      row_s1;
    logic [3:0]      row_s2;
    logic [1:0][3:0] acc;
    logic            last_dwell;
    logic            frame_done;
    logic [11:0]     bits;
    logic [3:0]      hits;
    logic [4:0]      dec;
    logic [3:0]      cls;
    logic            press;
    logic            held;
    logic            accept;
    logic [3:0]      press_num;
    logic            pop;

    assign last_dwell = run && dwell == 8'(SCAN_DIV - 1);
    assign frame_done = last_dwell && col == COL_C;
    assign col_a = run && col == COL_A;
    assign col_b = run && col == COL_B;
    assign col_c = run && col == COL_C;
    assign pop = key_valid && key_ready;
    assign accept = press && !held;

    // Column c's sample is still in the synchronizer when the frame closes, so it joins directly
    always_comb begin
        bits = {row_s2, acc[1], acc[0]};
        hits = 4'd0;
        dec = 5'd0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                if (bits[c*4+r]) begin
                    hits = hits + 4'd1;
                    dec = key_decode(col_t'(2'(c)), row_t'(2'(r)));
                end
        cls = (hits == 4'd0) ? KEY_NONE : (hits == 4'd1 && dec[4]) ? dec[3:0] : KEY_BAD;
    end

    keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_done (frame_done),
        .cls        (cls),
        .press      (press),
        .number     (press_num),
        .held       (held)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run        <= 1'b0;
            col        <= COL_A;
            dwell      <= 8'd0;
            row_s1     <= 4'd0;
            row_s2     <= 4'd0;
            acc        <= '0;
            key_valid  <= 1'b0;
            key_number <= 4'd0;
            overrun    <= 1'b0;
        end else begin
            run    <= 1'b1;
            row_s1 <= {row_g, row_f, row_e, row_d};
            row_s2 <= row_s1;
            if (run)
                dwell <= last_dwell ? 8'd0 : dwell + 8'd1;
            if (last_dwell) begin
                col <= (col == COL_C) ? COL_A : col_t'(col + 2'd1);
                if (col != COL_C)
                    acc[col[0]] <= row_s2;
            end
            overrun <= accept && key_valid && !pop;
            if (accept && (!key_valid || pop)) begin
                key_valid  <= 1'b1;
                key_number <= press_num;
            end else if (pop) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan order, debounce, decode, handshake and overrun
module tb_keypad_scanner;

    localparam logic [11:0] K0 = 12'h080, K1 = 12'h001, K3 = 12'h100, K4 = 12'h002, K5 = 12'h020;
    localparam logic [11:0] K6 = 12'h200, K7 = 12'h004, K9 = 12'h400, STAR = 12'h008, HASH = 12'h800;

    logic        clk;
    logic        rst_n;
    logic        col_a, col_b, col_c;
    logic        row_d, row_e, row_f, row_g;
    logic        key_valid;
    logic [3:0]  key_number;
    logic        key_ready;
    logic        overrun;
    logic [11:0] keys;
    logic        prev_valid;
    logic [3:0]  last_num;
    int          checks, errors, ev, ov;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_a      (col_a),
        .col_b      (col_b),
        .col_c      (col_c),
        .row_d      (row_d),
        .row_e      (row_e),
        .row_f      (row_f),
        .row_g      (row_g),
        .key_valid  (key_valid),
        .key_number (key_number),
        .key_ready  (key_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: keys bit index = column*4 + row (d,e,f,g)
    always_comb begin
        row_d = (col_a & keys[0]) | (col_b & keys[4]) | (col_c & keys[8]);
        row_e = (col_a & keys[1]) | (col_b & keys[5]) | (col_c & keys[9]);
        row_f = (col_a & keys[2]) | (col_b & keys[6]) | (col_c & keys[10]);
        row_g = (col_a & keys[3]) | (col_b & keys[7]) | (col_c & keys[11]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (key_valid && !prev_valid) begin
                ev++;
                last_num = key_number;
            end
            if (overrun)
                ov++;
            prev_valid = key_valid;
        end
    endtask

    task automatic hold(input logic [11:0] k, input int n);
        keys = k;
        run(n);
    endtask

    initial begin
        checks = 0; errors = 0; ev = 0; ov = 0;
        prev_valid = 1'b0; last_num = 4'd0;
        rst_n = 1'b0; keys = 12'd0; key_ready = 1'b0;
        run(5);
        chk("rst_cols", {col_a, col_b, col_c}, 3'b000);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_number", key_number, 4'd0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            run(1);
            chk("scan_cols", {col_a, col_b, col_c}, 3'b100 >> (((k - 1) / 4) % 3));
        end
        // Pressed during frame 2: frames 2,3,4 are KEY5, frame 4 closes at edge 49
        keys = K5;
        run(35);
        chk("k5_not_yet", key_valid, 1'b0);
        run(1);
        chk("k5_valid", key_valid, 1'b1);
        chk("k5_number", key_number, 4'd5);
        key_ready = 1'b1;
        run(1);
        chk("k5_popped", key_valid, 1'b0);
        ev = 0;
        run(120);
        chk("k5_no_repeat", ev, 0);
        hold(12'd0, 48);
        chk("k5_release", ev, 0);
        hold(K5, 60);
        chk("k5_second", ev, 1);
        chk("k5_second_num", last_num, 4'd5);
        ev = 0;
        hold(12'd0, 48);
        hold(K0, 60);
        chk("k0_event", ev, 1);
        chk("k0_num", last_num, 4'd0);
        ev = 0;
        hold(12'd0, 48);
        hold(STAR, 120);
        hold(12'd0, 48);
        hold(HASH, 120);
        hold(12'd0, 48);
        chk("star_hash_none", ev, 0);
        hold(K7, 12);
        hold(12'd0, 12);
        chk("bounce_short", ev, 0);
        hold(K7, 36);
        hold(12'd0, 48);
        chk("bounce_event", ev, 1);
        chk("bounce_num", last_num, 4'd7);
        ev = 0;
        hold(K1 | K9, 60);
        chk("ghost_none", ev, 0);
        hold(K9, 48);
        chk("ghost_then_9", ev, 1);
        chk("ghost_9_num", last_num, 4'd9);
        hold(12'd0, 48);
        key_ready = 1'b0; ev = 0; ov = 0;
        hold(K3, 60);
        chk("ovr_first", ev, 1);
        chk("ovr_first_num", key_number, 4'd3);
        chk("ovr_no_pulse_yet", ov, 0);
        hold(12'd0, 48);
        hold(K4, 60);
        chk("ovr_pulse", ov, 1);
        chk("ovr_valid_hold", key_valid, 1'b1);
        chk("ovr_number_hold", key_number, 4'd3);
        key_ready = 1'b1;
        run(1);
        chk("ovr_popped", key_valid, 1'b0);
        hold(12'd0, 48);
        chk("ovr_no_more", ev, 1);
        ev = 0;
        hold(K6, 24);
        chk("k6_mid_debounce", ev, 0);
        rst_n = 1'b0; keys = 12'd0;
        run(3);
        chk("mid_rst_cols", {col_a, col_b, col_c}, 3'b000);
        chk("mid_rst_valid", key_valid, 1'b0);
        rst_n = 1'b1;
        run(1);
        chk("mid_rst_col_a", {col_a, col_b, col_c}, 3'b100);
        run(60);
        chk("k6_aborted", ev, 0);
        key_ready = 1'b0;
        hold(K6, 60);
        chk("pend_valid", key_valid, 1'b1);
        chk("pend_num", key_number, 4'd6);
        rst_n = 1'b0; keys = 12'd0;
        run(1);
        chk("pend_rst_valid", key_valid, 1'b0);
        chk("pend_rst_num", key_number, 4'd0);
        rst_n = 1'b1;
        run(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
